msg_buf: RTL and testbench
==========================

# msg_buf

Parametrised message buffer with stream-out playback. Bytes written on `wr`/`dat` are stored in order. A `disp` pulse replays the stored content, oldest first, over a valid/ready output stream. Playback does not destroy the contents, so `disp` may be repeated. Successor to the fixed 8-bit write-then-display memory: it adds configurable width and depth, full/overflow handling with a wrap mode, backpressure, and clear.

## Interface
- `DW`, 8, data width in bits
- `DEPTH`, 16, number of entries; must be a power of two and ≥ 2
- `WRAP`, 0, full behaviour: 0 = drop new writes when full; 1 = overwrite the oldest entry
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `wr`  in  1  write strobe
- `dat`  in  DW  write data
- `disp`  in  1  start-playback pulse
- `clr`  in  1  synchronous clear of buffer state
- `out_vld`  out  1  playback beat valid
- `out_rdy`  in  1  downstream ready
- `out_dat`  out  DW  playback data; 0 when `out_vld`=0
- `out_last`  out  1  final beat of the playback
- `busy`  out  1  playback in progress
- `done`  out  1  one-cycle pulse when a playback completes
- `cnt`  out  $clog2(DEPTH+1)  number of stored entries
- `full`  out  1  `cnt` == DEPTH
- `ovf`  out  1  sticky: a write was dropped (WRAP=0) or an entry was overwritten (WRAP=1)
- `wr_drop`  out  1  sticky: a write arrived while `busy`, or in the same cycle as `disp`

## Operation
- Storage is a circular buffer with write pointer `wp` and oldest-entry pointer `op`. Both pointers are $clog2(DEPTH) bits and wrap naturally.
- Write accepted when `wr`=1, state IDLE, `disp`=0 and `clr`=0:
  - Not full: store at `wp`, increment `wp` and `cnt`.
  - Full, WRAP=0: write dropped, `ovf` set.
  - Full, WRAP=1: store at `wp`, increment `wp` and `op`, `cnt` stays DEPTH, `ovf` set.
- `wr` while `busy`, or together with `disp`: write dropped, `wr_drop` set.
- State machine states: IDLE and PLAY.
  - IDLE to PLAY on `disp`=1 with `cnt`>0. Load read pointer `rp`=`op` and beat counter `rem`=`cnt`.
  - `disp` with `cnt`=0: stay in IDLE, pulse `done` next cycle, no beats.
  - PLAY: `out_vld`=1, `out_dat`=mem[`rp`], `out_last`=(`rem`==1). On `out_vld`&&`out_rdy`, advance `rp` and decrement `rem`. The last handshake returns the FSM to IDLE.
  - `disp` during PLAY is ignored.
- `clr`, highest priority:
  - Next cycle: `wp`=`op`=`cnt`=0, `ovf`=`wr_drop`=0, state IDLE.
  - An active playback is aborted: `out_vld` drops and no `done` pulse is issued.
  - Memory contents are not cleared.
- Reset values: all outputs 0, state IDLE, pointers 0. Memory is not reset. Reset mid-playback aborts it immediately and issues no `done`.

## Timing
- `disp` sampled at edge N: first `out_vld` at cycle N+1.
- With `out_rdy` held at 1, one beat per cycle. `cnt` beats end at cycle N+`cnt`.
- `done`=1 for exactly one cycle, the cycle after the last handshake. `busy`=0 in that same cycle.
- Stall: while `out_vld`=1 and `out_rdy`=0, `out_dat` and `out_last` hold stable.
- `cnt`, `full`, `ovf` and `wr_drop` update on the edge that samples the write, and are visible in the following cycle.
- A new `disp` is accepted in the cycle `done` is high, so back-to-back replays are possible.

## Configuration
- `MSG_BUF_DISP_PRINT_EN` defined:
  - Simulation-only `$write("%c")` of each accepted beat.
  - `$display("%m: %0d bytes", n)` on `done`.
- Undefined: no system tasks are compiled, and the RTL is purely synthesizable. Port behaviour is identical either way.

## Structure
- `msg_buf_pkg` holds:
  - the state enum typedef (`MSG_BUF_IDLE`, `MSG_BUF_PLAY`)
  - default parameter constants
  - the function computing `cnt` width
- Sub-module `msg_buf_mem`: DEPTH×DW array with 1 write port and 1 asynchronous read port. Contents are not reset.
- Top `msg_buf` holds the pointers, counters, FSM, flags and print hooks.

## Test plan
- Reset asserted mid-simulation for 10 ns: every output reads 0. Writes and playback resume cleanly after release.
- DW=8, DEPTH=16: write "Hello World" (11 bytes), then `disp` with `out_rdy`=1.
  - 11 beats 0x48…0x64 on consecutive cycles from N+1.
  - `out_last` on 0x64 (`d`), then `done` one cycle later.
  - A second `disp` replays the identical stream.
- WRAP=0, DEPTH=16: write 20 bytes 0x41…0x54. Expect `cnt`=16, `full`=1, `ovf`=1. Playback returns 0x41…0x50.
- WRAP=1, DEPTH=16: write the same 20 bytes. Expect `cnt`=16, `ovf`=1. Playback returns 0x45…0x54.
- Backpressure: toggle `out_rdy` as 1,0,0,1,… during playback.
  - No beat is lost or duplicated, and `out_dat` stays stable while stalled.
  - `wr` during PLAY sets `wr_drop` and leaves `cnt` unchanged.
- Edge cases:
  - `disp` on an empty buffer: `done` at N+1, `out_vld` never asserted.
  - `clr` at the third beat: `out_vld`=0 next cycle, no `done`, `cnt`=0.

Source files
------------

// File: rtl/msg_buf_pkg.sv
// rtl/msg_buf_pkg.sv - shared state type, defaults and count-width helper for msg_buf
package msg_buf_pkg;

    typedef enum logic {
        MSG_BUF_IDLE = 1'b0,
        MSG_BUF_PLAY = 1'b1
    } msg_buf_state_t;

    localparam int MSG_BUF_DEF_DW    = 8;
    localparam int MSG_BUF_DEF_DEPTH = 16;
    localparam int MSG_BUF_DEF_WRAP  = 0;

    // cnt must represent 0..DEPTH inclusive
    function automatic int msg_buf_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/msg_buf_mem.sv
// rtl/msg_buf_mem.sv - DEPTH x DW storage, one write port, one asynchronous read port
module msg_buf_mem #(
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/msg_buf.sv
// rtl/msg_buf.sv - message buffer with stream replay; MSG_BUF_DISP_PRINT_EN adds simulation print hooks
module msg_buf
    import msg_buf_pkg::*;
#(
    parameter int DW    = MSG_BUF_DEF_DW,
    parameter int DEPTH = MSG_BUF_DEF_DEPTH,
    parameter int WRAP  = MSG_BUF_DEF_WRAP
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr,
    input  logic [DW-1:0]                   dat,
    input  logic                            disp,
    input  logic                            clr,
    output logic                            out_vld,
    input  logic                            out_rdy,
    output logic [DW-1:0]                   out_dat,
    output logic                            out_last,
    output logic                            busy,
    output logic                            done,
    output logic [msg_buf_cnt_w(DEPTH)-1:0] cnt,
    output logic                            full,
    output logic                            ovf,
    output logic                            wr_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = msg_buf_cnt_w(DEPTH);

    msg_buf_state_t state, state_nxt;
    logic [AW-1:0]  wp, op, rp;
    logic [CW-1:0]  rem;
    logic [DW-1:0]  rd_dat;
    logic           wr_ok, mem_we, beat, last_beat;

    assign busy      = (state == MSG_BUF_PLAY);
    assign full      = (cnt == CW'(DEPTH));
    assign wr_ok     = wr && !busy && !disp && !clr;
    assign mem_we    = wr_ok && (!full || (WRAP != 0));
    assign out_vld   = busy;
    assign out_dat   = busy ? rd_dat : '0;
    assign out_last  = busy && (rem == CW'(1));
    assign beat      = out_vld && out_rdy;
    assign last_beat = beat && (rem == CW'(1));

    msg_buf_mem #(.DW(DW), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wp),
        .wdata (dat),
        .raddr (rp),
        .rdata (rd_dat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MSG_BUF_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = MSG_BUF_IDLE;
        end else begin
            case (state)
                MSG_BUF_IDLE: if (disp && (cnt != '0)) state_nxt = MSG_BUF_PLAY;
                MSG_BUF_PLAY: if (last_beat) state_nxt = MSG_BUF_IDLE;
                default:      state_nxt = MSG_BUF_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp      <= '0;
            op      <= '0;
            rp      <= '0;
            rem     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            wr_drop <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clr) begin
                // Abort without done; memory contents are deliberately kept
                wp      <= '0;
                op      <= '0;
                cnt     <= '0;
                ovf     <= 1'b0;
                wr_drop <= 1'b0;
            end else begin
                if (wr && (busy || disp)) begin
                    wr_drop <= 1'b1;
                end
                if (wr_ok) begin
                    if (!full) begin
                        wp  <= wp + AW'(1);
                        cnt <= cnt + CW'(1);
                    end else begin
                        ovf <= 1'b1;
                        if (WRAP != 0) begin
                            wp <= wp + AW'(1);
                            op <= op + AW'(1);
                        end
                    end
                end
                if (!busy && disp) begin
                    rp  <= op;
                    rem <= cnt;
                    if (cnt == '0) done <= 1'b1;
                end
                if (beat) begin
                    rp  <= rp + AW'(1);
                    rem <= rem - CW'(1);
                    if (rem == CW'(1)) done <= 1'b1;
                end
            end
        end
    end

`ifdef MSG_BUF_DISP_PRINT_EN
    int unsigned print_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            print_n <= 0;
        end else if (clr) begin
            print_n <= 0;
        end else begin
            if (done) begin
                $display("%m: %0d bytes", print_n);
                print_n <= 0;
            end
            if (beat) begin
                $write("%c", out_dat);
                print_n <= print_n + 1;
            end
        end
    end
`else
    // Synthesizable build: no print hooks.
`endif

endmodule

// File: tb/tb_msg_buf.sv
// tb/tb_msg_buf.sv - randomized self-checking bench for msg_buf, WRAP=0 and WRAP=1 side by side
module tb_msg_buf;

    logic       clk, rst, wr, disp, clr, out_rdy;
    logic [7:0] dat;

    logic       out_vld0, out_last0, busy0, done0, full0, ovf0, wr_drop0;
    logic [7:0] out_dat0;
    logic [4:0] cnt0;
    logic       out_vld1, out_last1, busy1, done1, full1, ovf1, wr_drop1;
    logic [7:0] out_dat1;
    logic [4:0] cnt1;

    int total = 0;
    int bad   = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         m_ovf0, m_ovf1, m_wdrop;

    msg_buf #(.DW(8), .DEPTH(16), .WRAP(0)) dut0 (
        .clk(clk), .rst(rst), .wr(wr), .dat(dat), .disp(disp), .clr(clr),
        .out_vld(out_vld0), .out_rdy(out_rdy), .out_dat(out_dat0), .out_last(out_last0),
        .busy(busy0), .done(done0), .cnt(cnt0), .full(full0), .ovf(ovf0), .wr_drop(wr_drop0)
    );

    msg_buf #(.DW(8), .DEPTH(16), .WRAP(1)) dut1 (
        .clk(clk), .rst(rst), .wr(wr), .dat(dat), .disp(disp), .clr(clr),
        .out_vld(out_vld1), .out_rdy(out_rdy), .out_dat(out_dat1), .out_last(out_last1),
        .busy(busy1), .done(done1), .cnt(cnt1), .full(full1), .ovf(ovf1), .wr_drop(wr_drop1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q0.delete();
        q1.delete();
        m_ovf0  = 1'b0;
        m_ovf1  = 1'b0;
        m_wdrop = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".vld0"}, 32'(out_vld0), 0);    chk({tag, ".vld1"}, 32'(out_vld1), 0);
        chk({tag, ".dat0"}, 32'(out_dat0), 0);    chk({tag, ".dat1"}, 32'(out_dat1), 0);
        chk({tag, ".last0"}, 32'(out_last0), 0);  chk({tag, ".last1"}, 32'(out_last1), 0);
        chk({tag, ".busy0"}, 32'(busy0), 0);      chk({tag, ".busy1"}, 32'(busy1), 0);
        chk({tag, ".done0"}, 32'(done0), 0);      chk({tag, ".done1"}, 32'(done1), 0);
        chk({tag, ".cnt0"}, 32'(cnt0), 0);        chk({tag, ".cnt1"}, 32'(cnt1), 0);
        chk({tag, ".full0"}, 32'(full0), 0);      chk({tag, ".full1"}, 32'(full1), 0);
        chk({tag, ".ovf0"}, 32'(ovf0), 0);        chk({tag, ".ovf1"}, 32'(ovf1), 0);
        chk({tag, ".wrdrop0"}, 32'(wr_drop0), 0); chk({tag, ".wrdrop1"}, 32'(wr_drop1), 0);
    endtask

    task automatic chk_status(input string tag);
        chk({tag, ".cnt0"}, 32'(cnt0), q0.size());
        chk({tag, ".cnt1"}, 32'(cnt1), q1.size());
        chk({tag, ".full0"}, 32'(full0), 32'(q0.size() == 16));
        chk({tag, ".full1"}, 32'(full1), 32'(q1.size() == 16));
        chk({tag, ".ovf0"}, 32'(ovf0), 32'(m_ovf0));
        chk({tag, ".ovf1"}, 32'(ovf1), 32'(m_ovf1));
        chk({tag, ".wrdrop0"}, 32'(wr_drop0), 32'(m_wdrop));
        chk({tag, ".wrdrop1"}, 32'(wr_drop1), 32'(m_wdrop));
    endtask

    // Called at a falling edge; one write per cycle
    task automatic wr_byte(input logic [7:0] b);
        wr  = 1'b1;
        dat = b;
        @(negedge clk);
        wr  = 1'b0;
        if (q0.size() < 16) q0.push_back(b);
        else m_ovf0 = 1'b1;
        if (q1.size() == 16) begin
            void'(q1.pop_front());
            m_ovf1 = 1'b1;
        end
        q1.push_back(b);
    endtask

    // mode: 0 = ready always, 1 = ready pattern 1,0,0,1, 2 = random ready
    task automatic playback(input int mode, input int wr_at, input int clr_at, input bit wr_with_disp);
        int n, idx, k;
        bit r;
        n = q0.size();
        disp = 1'b1;
        if (wr_with_disp) begin
            wr = 1'b1;
            dat = 8'hEE;
            m_wdrop = 1'b1;
        end
        @(negedge clk);
        disp = 1'b0;
        wr   = 1'b0;
        idx  = 0;
        k    = 0;
        while (idx < n && k < 400) begin
            chk("play.vld0", 32'(out_vld0), 1);
            chk("play.vld1", 32'(out_vld1), 1);
            chk("play.dat0", 32'(out_dat0), 32'(q0[idx]));
            chk("play.dat1", 32'(out_dat1), 32'(q1[idx]));
            chk("play.last0", 32'(out_last0), 32'(idx == n - 1));
            chk("play.busy1", 32'(busy1), 1);
            chk("play.done0", 32'(done0), 0);
            if (idx == clr_at) begin
                clr = 1'b1;
                out_rdy = 1'b1;
                @(negedge clk);
                clr = 1'b0;
                out_rdy = 1'b0;
                model_clear();
                chk("clr.vld0", 32'(out_vld0), 0);
                chk("clr.vld1", 32'(out_vld1), 0);
                chk("clr.done0", 32'(done0), 0);
                chk("clr.cnt0", 32'(cnt0), 0);
                chk("clr.cnt1", 32'(cnt1), 0);
                @(negedge clk);
                chk("clr.done_late0", 32'(done0), 0);
                chk("clr.done_late1", 32'(done1), 0);
                return;
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (k % 4 == 0) || (k % 4 == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_rdy = r;
            if (k == wr_at) begin
                wr  = 1'b1;
                dat = 8'($urandom);
                m_wdrop = 1'b1;
            end
            @(negedge clk);
            out_rdy = 1'b0;
            wr = 1'b0;
            if (r) idx++;
            k++;
        end
        chk("play.beats", idx, n);
        if (mode == 0) chk("play.cycles", k, n);
        chk("end.done0", 32'(done0), 1);
        chk("end.done1", 32'(done1), 1);
        chk("end.busy0", 32'(busy0), 0);
        chk("end.vld0", 32'(out_vld0), 0);
        chk("end.vld1", 32'(out_vld1), 0);
        chk("end.dat0", 32'(out_dat0), 0);
        @(negedge clk);
        chk("end.done_once0", 32'(done0), 0);
        chk("end.done_once1", 32'(done1), 0);
    endtask

    initial begin
        string hello;
        hello   = "Hello World";
        rst     = 1'b1;
        wr      = 1'b0;
        dat     = 8'h00;
        disp    = 1'b0;
        clr     = 1'b0;
        out_rdy = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < hello.len(); i++) wr_byte(hello[i]);
        chk_status("hello");
        playback(0, -1, -1, 1'b0);
        playback(0, -1, -1, 1'b0);

        playback(1, 3, -1, 1'b0);
        chk_status("backpressure");

        disp = 1'b1;
        @(negedge clk);
        disp = 1'b0;
        out_rdy = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_zero("rst_mid");
        #9;
        rst = 1'b0;
        out_rdy = 1'b0;
        model_clear();
        @(negedge clk);
        chk_zero("rst_after");

        playback(0, -1, -1, 1'b1);
        chk_status("empty_disp");

        for (int i = 0; i < 20; i++) wr_byte(8'h41 + 8'(i));
        chk_status("overflow");
        playback(0, -1, -1, 1'b0);
        playback(2, -1, 2, 1'b0);
        chk_status("after_clr");

        for (int i = 0; i < 7; i++) wr_byte(8'($urandom));
        chk_status("random");
        playback(2, -1, -1, 1'b0);
        playback(2, 1, -1, 1'b0);
        chk_status("random_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
